mmio_uart_tx: RTL and testbench

Memory-mapped UART transmitter that answers the single-cycle core's data-memory bus as a responder alongside the data memory. The core stores bytes to a TX data register; the block queues them in a small FIFO and serializes them 8N1, LSB first, on a single output line. A status register is readable combinationally, so a load completes in the core's single cycle. The top level uses `hit` to steer `readData` between this block and the data memory, and to suppress data-memory writes inside the window.

---
 rtl/mmio_uart_tx.sv | 175 +++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: TX FIFO, combinational STATUS read.
// Ports: clk, reset, memWrite, dataAddress, storeData, readData, hit, txd.
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0100,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memWrite,
  input  logic [31:0] dataAddress,
  input  logic [31:0] storeData,
  output logic [31:0] readData,
  output logic        hit,
  output logic        txd
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);

  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
  localparam logic [BW-1:0] BAUD_END = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t        state;
  logic [BW-1:0] baud;
  logic [2:0]    bitcnt;
  logic [7:0]    shift;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [CW-1:0] count;
  logic          overflow;

  logic       full;
  logic       empty;
  logic       busy;
  logic       baud_last;
  logic [1:0] off;
  logic       wr_tx;
  logic       wr_stat;
  logic       push;
  logic       drop;
  logic       pop;
  logic [7:0] head;

  logic unused_bits;
  assign unused_bits = ^{dataAddress[1:0], storeData[31:8]};

  assign hit       = dataAddress[31:4] == BASE_ADDR[31:4];
  assign off       = dataAddress[3:2];
  assign full      = count == FULL_CNT;
  assign empty     = count == '0;
  assign busy      = state != IDLE;
  assign baud_last = baud == BAUD_END;

  assign wr_tx   = hit && memWrite && off == 2'd0;
  assign wr_stat = hit && memWrite && off == 2'd1;
  // Full is judged before the edge: a pop on the same edge does not rescue it.
  assign push    = wr_tx && !full;
  assign drop    = wr_tx && full;

  // Pop from IDLE, or at the end of STOP so frames run back-to-back.
  assign pop  = !empty && (state == IDLE ||
                (state == STOP && baud_last));
  assign head = mem[rptr];

  always_comb begin
    readData = '0;
    if (hit) begin
      unique case (1'b1)
        off == 2'd1:
          readData = {24'd0, 4'(count), overflow, empty, full, busy};
        default:
          readData = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr] <= storeData[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      // Setting wins over a same-edge STATUS clear.
      if (drop)         overflow <= 1'b1;
      else if (wr_stat) overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      txd    <= 1'b1;
      baud   <= '0;
      bitcnt <= '0;
      shift  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          txd <= 1'b1;
          if (!empty) begin
            shift  <= head;
            bitcnt <= '0;
            baud   <= '0;
            txd    <= 1'b0;
            state  <= START;
          end
        end
        START: begin
          if (baud_last) begin
            baud  <= '0;
            txd   <= shift[0];
            state <= DATA;
          end else begin
            baud <= baud + 1'b1;
          end
        end
        DATA: begin
          if (baud_last) begin
            baud   <= '0;
            shift  <= {1'b0, shift[7:1]};
            bitcnt <= bitcnt + 1'b1;
            if (bitcnt == 3'd7) begin
              txd   <= 1'b1;
              state <= STOP;
            end else begin
              txd <= shift[1];
            end
          end else begin
            baud <= baud + 1'b1;
          end
        end
        STOP: begin
          if (baud_last) begin
            baud <= '0;
            if (!empty) begin
              shift  <= head;
              bitcnt <= '0;
              txd    <= 1'b0;
              state  <= START;
            end else begin
              txd   <= 1'b1;
              state <= IDLE;
            end
          end else begin
            baud <= baud + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: bus stores, serial receiver model, byte scoreboard.
// Runs with CLKS_PER_BIT=4, FIFO_DEPTH=4.
module tb_mmio_uart_tx;

  localparam logic [31:0] BASE = 32'h0000_0100;
  localparam logic [31:0] STAT = BASE + 32'd4;
  localparam int CPB = 4;
  localparam int FL  = 10 * CPB;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        memWrite = 1'b0;
  logic [31:0] dataAddress = STAT;
  logic [31:0] storeData = '0;
  logic [31:0] readData;
  logic        hit;
  logic        txd;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [7:0] exp_q[$];
  int         start_q[$];
  logic       rst_seen = 1'b0;
  logic       mon_busy = 1'b0;

  mmio_uart_tx #(
    .BASE_ADDR(BASE),
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .memWrite(memWrite),
    .dataAddress(dataAddress),
    .storeData(storeData),
    .readData(readData),
    .hit(hit),
    .txd(txd)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset) rst_seen <= 1'b1;
  end

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Serial receiver: samples txd once per cycle on the falling clock edge.
  logic [FL-1:0] s;
  logic [7:0]    rb;
  logic          fok;
  logic [7:0]    eb;
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && txd === 1'b0) begin
        mon_busy = 1'b1;
        start_q.push_back(cyc);
        rst_seen = 1'b0;
        s = '0;
        for (int i = 1; i < FL; i++) begin
          @(negedge clk);
          s[i] = txd;
        end
        if (!rst_seen) begin
          fok = 1'b1;
          for (int i = 0; i < CPB; i++) begin
            if (s[i] !== 1'b0) fok = 1'b0;
            if (s[FL-1-i] !== 1'b1) fok = 1'b0;
          end
          for (int b = 0; b < 8; b++) begin
            rb[b] = s[CPB + CPB*b];
            for (int j = 1; j < CPB; j++)
              if (s[CPB + CPB*b + j] !== rb[b]) fok = 1'b0;
          end
          chk("frame_fmt", {31'd0, fok}, 32'd1);
          if (exp_q.size() == 0) begin
            chk("unexpected_frame", {24'd0, rb}, 32'hFFFF_FFFF);
          end else begin
            eb = exp_q.pop_front();
            chk("rx_byte", {24'd0, rb}, {24'd0, eb});
          end
        end
        mon_busy = 1'b0;
      end
    end
  end

  // Called at a falling edge; the store lands on the next rising edge.
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    memWrite = 1'b1;
    dataAddress = a;
    storeData = d;
    @(negedge clk);
    memWrite = 1'b0;
    dataAddress = STAT;
  endtask

  task automatic wr_tx(input logic [7:0] d, input bit dropped);
    if (!dropped) exp_q.push_back(d);
    wr(BASE, {24'hABCDEF, d});
  endtask

  task automatic wait_done(input int budget, output int busy_cyc);
    int n;
    n = 0;
    busy_cyc = 0;
    dataAddress = STAT;
    do begin
      @(negedge clk);
      n++;
      if (readData[0]) busy_cyc++;
    end while ((exp_q.size() != 0 || readData[0] || mon_busy)
               && n < budget);
    if (n >= budget) chk("timeout", 32'd0, 32'd1);
  endtask

  int bc;
  int e0;
  int s0;
  int nf;
  int lows;

  initial begin
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("reset_status", readData, 32'h4);
    chk("reset_txd", {31'd0, txd}, 32'd1);
    chk("reset_hit", {31'd0, hit}, 32'd1);

    // Single frame
    s0 = start_q.size();
    wr_tx(8'hA5, 1'b0);
    e0 = cyc;
    wait_done(200, bc);
    chk("busy_cycles", bc, FL);
    chk("frames_single", start_q.size() - s0, 1);
    if (start_q.size() > s0)
      chk("start_latency", start_q[s0] - e0, 1);

    // Overflow: sixth store dropped
    s0 = start_q.size();
    for (int i = 1; i <= 6; i++)
      wr_tx(8'(i), i == 6);
    #1;
    chk("ovf_status", readData, 32'h4B);
    wr(STAT, 32'h0);
    #1;
    chk("ovf_clear", readData, 32'h43);
    wait_done(400, bc);
    chk("ovf_frames", start_q.size() - s0, 5);
    for (int i = 1; i < 5; i++)
      if (s0 + i < start_q.size())
        chk("frame_gap", start_q[s0+i] - start_q[s0+i-1], FL);
    chk("ovf_q_empty", exp_q.size(), 0);

    // Address decode
    s0 = start_q.size();
    memWrite = 1'b1;
    storeData = 32'h77;
    dataAddress = BASE + 32'h10;
    #1;
    chk("dec_out_hit", {31'd0, hit}, 32'd0);
    chk("dec_out_rd", readData, 32'd0);
    @(negedge clk);
    dataAddress = BASE + 32'h8;
    #1;
    chk("dec_rsv_hit", {31'd0, hit}, 32'd1);
    chk("dec_rsv_rd", readData, 32'd0);
    @(negedge clk);
    memWrite = 1'b0;
    dataAddress = BASE;
    #1;
    chk("dec_txdata_rd", readData, 32'd0);
    dataAddress = STAT;
    #1;
    chk("dec_status", readData, 32'h4);
    repeat (10) @(negedge clk);
    chk("dec_no_frame", start_q.size() - s0, 0);

    // Reset mid-frame
    wr_tx(8'h11, 1'b0);
    wr_tx(8'h22, 1'b0);
    wr_tx(8'h33, 1'b0);
    repeat (12) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    #1;
    chk("rst_mid_txd", {31'd0, txd}, 32'd1);
    chk("rst_mid_status", readData, 32'h4);
    nf = start_q.size();
    lows = 0;
    repeat (100) begin
      @(negedge clk);
      if (txd !== 1'b1) lows++;
    end
    chk("rst_mid_txd_low", lows, 0);
    chk("rst_mid_frames", start_q.size() - nf, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
